mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Parametrised multicycle control unit for the 16-bit MIPS core. It replaces the fixed controller between the instruction register and the datapath. It adds `beq`, `addi` and `j` support, a memory-ready handshake, an illegal-instruction trap mode and a retired-instruction counter. It drives the datapath strobes and mux selects from a Moore FSM; only `PCEn` depends combinationally on `zero`.

## Interface
- `HAS_MEM_HANDSHAKE`, 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored, treated as always 1.
- `TRAP_ON_ILLEGAL`, 1: 1 = undefined opcode/funct enters TRAP; 0 = treated as NOP, return to FETCH.
- `CNT_W`, 16: width of retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `opcode`  in  6  IR[31:26] from datapath.
- `funct`  in  6  IR[5:0] from datapath.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes access this cycle.
- `PCEn`  out  1  PC write enable = PCWrite | (Branch & zero).
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `Memwrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  write register: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  register file write strobe.
- `ALUsrcA`  out  1  0 = PC, 1 = reg A.
- `ALUsrcB`  out  2  00 = reg B, 01 = PC increment constant, 10 = sign-imm, 11 = sign-imm << 1.
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal`  out  1  sticky trap flag.
- `retired`  out  CNT_W  count of completed instructions.
- `state_dbg`  out  4  current state encoding.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type functs: add 100000, sub 100010, and 100100, or 100101, slt 101010. Any other funct is illegal.
- Each state and its required outputs (unlisted strobes 0, unlisted selects 0):
  - FETCH: ALUsrcB=01, ALUControl=add; IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready.
  - DECODE: ALUsrcB=11, add (branch target into ALUOut). Dispatch on opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP. Illegal→TRAP, or →FETCH when TRAP_ON_ILLEGAL=0.
  - MEMADR: ALUsrcA=1, ALUsrcB=10, add. lw→MEMRD, sw→MEMWR.
  - MEMRD: IorD=1. Go to MEMWB on mem_ready.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
  - MEMWR: IorD=1, Memwrite=mem_ready. Go to FETCH on mem_ready.
  - EXEC: ALUsrcA=1, ALUsrcB=00, ALUControl from funct. Go to ALUWB; illegal funct handled as in DECODE.
  - ALUWB: RegWrite=1, RegDst=1. Go to FETCH.
  - BRANCH: ALUsrcA=1, sub, PCsrc=01, Branch=1. Go to FETCH.
  - ADDIEX: ALUsrcA=1, ALUsrcB=10, add. Go to ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0. Go to FETCH.
  - JUMP: PCsrc=10, PCWrite=1. Go to FETCH.
  - TRAP: all strobes 0, illegal=1. Exit only by reset.
- Any state entering FETCH (except from TRAP) increments `retired`; this includes illegal-as-NOP. `retired` wraps modulo 2^CNT_W.

## Timing
- Latency with no memory waits, FETCH through last state: beq/j 3, R/sw/addi 4, lw 5 cycles. Each low `mem_ready` cycle in FETCH/MEMRD/MEMWR adds one cycle.
- While `rst`=0: state=FETCH, all strobes (PCEn, IRWrite, Memwrite, RegWrite) forced 0, illegal=0, retired=0. Selects show FETCH decode.
- First FETCH after reset release begins on the first rising edge with `rst`=1.
- Reset mid-instruction aborts it; the aborted instruction is not counted.
- `mem_ready` high outside memory states is ignored.
- Memwrite and IRWrite never assert for more than one cycle per access.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams;
  - ALUControl codes;
  - state enum (4-bit);
  - ALUsrcB and PCsrc select codes.
- One sub-module `alu_decoder`: maps funct and the FSM ALU-op to ALUControl, and flags illegal functs.

## Test plan
- Reset asserted mid-MEMRD of lw → state_dbg=FETCH, strobes 0, retired=0.
- add (funct 100000) with `mem_ready` tied 1 → 4 cycles; RegWrite=1, RegDst=1 in cycle 4; retired 0→1.
- lw with `mem_ready` low 2 cycles in FETCH and in MEMRD → 9 cycles; IRWrite one pulse; MemtoReg=1 at writeback.
- beq with zero=1 → PCEn=1, PCsrc=01 in BRANCH. With zero=0 → PCEn=0; both take 3 cycles.
- j → PCsrc=10, PCEn=1 in cycle 3. sw → exactly one Memwrite pulse, no RegWrite.
- Opcode 111111:
  - TRAP_ON_ILLEGAL=1 → illegal=1, stuck until rst=0.
  - TRAP_ON_ILLEGAL=0 → FETCH after DECODE, retired+1.
  - CNT_W=4, 16 instructions → retired wraps to 0.

Source files
------------

// File: rtl/mips_mc_controller_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS control unit.
//   - opcode / R-type funct values understood by the controller
//   - ALUControl codes, FSM ALU-op requests
//   - ALUsrcB and PCsrc select codes
//   - 4-bit FSM state enum (also exported on state_dbg)
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_INC   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // What the FSM asks of the ALU; NONE leaves ALUControl at 000.
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// mips_mc_controller_if: controller <-> datapath bundle.
//   master: controller side (takes IR fields / zero / mem_ready, drives strobes and selects)
//   slave : datapath side
interface mips_mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCEn;
  logic       IorD;
  logic       Memwrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCsrc;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUsrcA, ALUsrcB, ALUControl, PCsrc
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUsrcA, ALUsrcB, ALUControl, PCsrc
  );
endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// alu_decoder: turns the FSM ALU-op request plus the R-type funct into
// ALUControl, and flags functs the core does not implement.
//   aluop      in  FSM request (none/add/sub/funct)
//   funct      in  IR[5:0]
//   alucontrol out ALU operation code
//   bad_funct  out funct unsupported (only meaningful for ALUOP_FUNCT)
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = 3'b000;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: Moore multicycle control FSM for the 16-bit MIPS core.
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-low reset
//   bus       master modport: IR fields, zero, mem_ready in; strobes/selects out
//   illegal   out sticky trap indication (held until reset)
//   retired   out completed-instruction count, wraps at 2^CNT_W
//   state_dbg out current state encoding
// Only PCEn looks at an input (zero) combinationally; memory-side strobes
// follow mem_ready so each access produces a single-cycle pulse.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter bit HAS_MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ON_ILLEGAL   = 1'b1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  mips_mc_controller_if.master bus,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_t     state, nxt;
  aluop_t     aluop;
  logic       mr, bad_funct;
  logic       pcwrite, branch, irwrite, memwrite, regwrite;
  logic [2:0] alucontrol;

  // Without a handshake every memory access completes in one cycle.
  assign mr = HAS_MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      // FETCH->FETCH is a memory wait, not a retirement; TRAP never leaves.
      if (nxt == S_FETCH && state != S_FETCH && state != S_TRAP)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt          = state;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite      = 1'b0;
    memwrite     = 1'b0;
    regwrite     = 1'b0;
    bus.IorD     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUsrcA  = 1'b0;
    bus.ALUsrcB  = SRCB_REG;
    bus.PCsrc    = PCSRC_ALU;
    aluop        = ALUOP_NONE;
    case (state)
      S_FETCH: begin
        bus.ALUsrcB = SRCB_INC;
        aluop       = ALUOP_ADD;
        irwrite     = mr;
        pcwrite     = mr;
        if (mr) nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        bus.ALUsrcB = SRCB_IMMSH;
        aluop       = ALUOP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = SRCB_IMM;
        aluop       = ALUOP_ADD;
        nxt         = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD = 1'b1;
        if (mr) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite     = 1'b1;
        bus.MemtoReg = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEMWR: begin
        bus.IorD = 1'b1;
        memwrite = mr;
        if (mr) nxt = S_FETCH;
      end
      S_EXEC: begin
        bus.ALUsrcA = 1'b1;
        aluop       = ALUOP_FUNCT;
        if (bad_funct) nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        else           nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        bus.RegDst = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUsrcA = 1'b1;
        aluop       = ALUOP_SUB;
        bus.PCsrc   = PCSRC_ALUOUT;
        branch      = 1'b1;
        nxt         = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = SRCB_IMM;
        aluop       = ALUOP_ADD;
        nxt         = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_JUMP: begin
        bus.PCsrc = PCSRC_JUMP;
        pcwrite   = 1'b1;
        nxt       = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing fires while the FSM is held in FETCH.
  assign bus.PCEn       = rst & (pcwrite | (branch & bus.zero));
  assign bus.IRWrite    = rst & irwrite;
  assign bus.Memwrite   = rst & memwrite;
  assign bus.RegWrite   = rst & regwrite;
  assign bus.ALUControl = alucontrol;
  assign illegal        = (state == S_TRAP);
  assign state_dbg      = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rst_v;
  logic [5:0] op, fn;
  logic       z, mr;

  logic        ill0, ill1;
  logic [15:0] ret0;
  logic [3:0]  ret1;
  logic [3:0]  st0, st1;

  mips_mc_controller_if dif0 ();
  mips_mc_controller_if dif1 ();

  assign dif0.opcode = op;  assign dif0.funct = fn;
  assign dif0.zero = z;     assign dif0.mem_ready = mr;
  assign dif1.opcode = op;  assign dif1.funct = fn;
  assign dif1.zero = z;     assign dif1.mem_ready = mr;

  mips_mc_controller #(.HAS_MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(dif0.master), .illegal(ill0), .retired(ret0), .state_dbg(st0));

  mips_mc_controller #(.HAS_MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(dif1.master), .illegal(ill1), .retired(ret1), .state_dbg(st1));

  always #5 clk = ~clk;

  // strobe nibble = {PCEn, IRWrite, Memwrite, RegWrite}
  localparam logic [3:0] NO = 4'b0000, FE = 4'b1100, PC = 4'b1000, MW = 4'b0010, RW = 4'b0001;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    int          w;
    logic [3:0]  st;
    logic [3:0]  strb;
    logic        ill;
    logic [15:0] ret;
    bit          sc;
    logic [10:0] sel;  // {RegDst,MemtoReg,IorD,ALUsrcA,ALUsrcB,PCsrc,ALUControl}
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  // Drive one cycle of inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input logic [5:0] o, f, input logic zz, m,
                     input logic [3:0] s, b, input int r,
                     input logic il = 1'b0, input int w = 0);
    exp_t e;
    @(posedge clk); #1;
    rst = rst_v; op = o; fn = f; z = zz; mr = m;
    e.w = w; e.st = s; e.strb = b; e.ill = il; e.ret = 16'(r); e.sc = 1'b0; e.sel = '0;
    q.push_back(e);
  endtask

  // Add select expectations to the most recently queued cycle.
  task automatic sel(input logic rd, mt, io, sa, input logic [1:0] sb, pc, input logic [2:0] ac);
    exp_t e;
    e = q.pop_back();
    e.sc = 1'b1;
    e.sel = {rd, mt, io, sa, sb, pc, ac};
    q.push_back(e);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [2:0] ac, input int r);
    cyc(OP_RTYPE, f, 0, 1, S_FETCH,  FE, r);
    cyc(OP_RTYPE, f, 0, 1, S_DECODE, NO, r);
    cyc(OP_RTYPE, f, 0, 1, S_EXEC,   NO, r); sel(0, 0, 0, 1, 2'b00, 2'b00, ac);
    cyc(OP_RTYPE, f, 0, 1, S_ALUWB,  RW, r); sel(1, 0, 0, 0, 2'b00, 2'b00, 3'b000);
  endtask

  // Monitor: compare every queued expectation against the selected DUT.
  exp_t        me;
  logic [3:0]  a_st, a_strb;
  logic        a_ill;
  logic [15:0] a_ret;
  logic [10:0] a_sel;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      n_cyc++;
      if (me.w == 0) begin
        a_st = st0; a_ill = ill0; a_ret = ret0;
        a_strb = {dif0.PCEn, dif0.IRWrite, dif0.Memwrite, dif0.RegWrite};
        a_sel = {dif0.RegDst, dif0.MemtoReg, dif0.IorD, dif0.ALUsrcA, dif0.ALUsrcB, dif0.PCsrc, dif0.ALUControl};
      end else begin
        a_st = st1; a_ill = ill1; a_ret = {12'b0, ret1};
        a_strb = {dif1.PCEn, dif1.IRWrite, dif1.Memwrite, dif1.RegWrite};
        a_sel = {dif1.RegDst, dif1.MemtoReg, dif1.IorD, dif1.ALUsrcA, dif1.ALUsrcB, dif1.PCsrc, dif1.ALUControl};
      end
      n_assert++;
      if (a_st !== me.st || a_strb !== me.strb || a_ill !== me.ill || a_ret !== me.ret ||
          (me.sc && a_sel !== me.sel)) begin
        n_fail++;
        $display("FAIL cyc%0d dut%0d: got st=%0d strb=%b ill=%b ret=%0d sel=%b, want st=%0d strb=%b ill=%b ret=%0d sel=%b (sel checked=%0b)",
                 n_cyc, me.w, a_st, a_strb, a_ill, a_ret, a_sel, me.st, me.strb, me.ill, me.ret, me.sel, me.sc);
      end
    end
  end

  initial begin
    rst_v = 1'b0; rst = 1'b0; op = OP_LW; fn = '0; z = 1'b0; mr = 1'b1;

    // reset state: FETCH, strobes forced low even with mem_ready high
    cyc(OP_LW, 0, 0, 1, S_FETCH, NO, 0); sel(0, 0, 0, 0, 2'b01, 2'b00, ALU_ADD);
    cyc(OP_LW, 0, 0, 1, S_FETCH, NO, 0);
    rst_v = 1'b1;
    cyc(OP_LW, 0, 0, 0, S_FETCH, NO, 0);

    // lw aborted by reset in MEMRD
    cyc(OP_LW, 0, 0, 1, S_FETCH,  FE, 0);
    cyc(OP_LW, 0, 0, 1, S_DECODE, NO, 0); sel(0, 0, 0, 0, 2'b11, 2'b00, ALU_ADD);
    cyc(OP_LW, 0, 0, 1, S_MEMADR, NO, 0); sel(0, 0, 0, 1, 2'b10, 2'b00, ALU_ADD);
    cyc(OP_LW, 0, 0, 0, S_MEMRD,  NO, 0); sel(0, 0, 1, 0, 2'b00, 2'b00, 3'b000);
    rst_v = 1'b0;
    cyc(OP_LW, 0, 0, 1, S_FETCH, NO, 0); sel(0, 0, 0, 0, 2'b01, 2'b00, ALU_ADD);
    cyc(OP_LW, 0, 0, 1, S_FETCH, NO, 0);
    rst_v = 1'b1;
    cyc(OP_LW, 0, 0, 0, S_FETCH, NO, 0);

    // R-type, no waits
    rtype(F_ADD, ALU_ADD, 0);
    rtype(F_SUB, ALU_SUB, 1);
    rtype(F_SLT, ALU_SLT, 2);

    // lw with two wait cycles in FETCH and in MEMRD
    cyc(OP_LW, 0, 0, 0, S_FETCH,  NO, 3);
    cyc(OP_LW, 0, 0, 0, S_FETCH,  NO, 3);
    cyc(OP_LW, 0, 0, 1, S_FETCH,  FE, 3);
    cyc(OP_LW, 0, 0, 1, S_DECODE, NO, 3);
    cyc(OP_LW, 0, 0, 1, S_MEMADR, NO, 3);
    cyc(OP_LW, 0, 0, 0, S_MEMRD,  NO, 3);
    cyc(OP_LW, 0, 0, 0, S_MEMRD,  NO, 3);
    cyc(OP_LW, 0, 0, 1, S_MEMRD,  NO, 3);
    cyc(OP_LW, 0, 0, 1, S_MEMWB,  RW, 3); sel(0, 1, 0, 0, 2'b00, 2'b00, 3'b000);

    // beq taken / not taken
    cyc(OP_BEQ, 0, 0, 1, S_FETCH,  FE, 4);
    cyc(OP_BEQ, 0, 0, 1, S_DECODE, NO, 4);
    cyc(OP_BEQ, 0, 1, 1, S_BRANCH, PC, 4); sel(0, 0, 0, 1, 2'b00, 2'b01, ALU_SUB);
    cyc(OP_BEQ, 0, 0, 1, S_FETCH,  FE, 5);
    cyc(OP_BEQ, 0, 0, 1, S_DECODE, NO, 5);
    cyc(OP_BEQ, 0, 0, 1, S_BRANCH, NO, 5); sel(0, 0, 0, 1, 2'b00, 2'b01, ALU_SUB);

    // j
    cyc(OP_J, 0, 0, 1, S_FETCH,  FE, 6);
    cyc(OP_J, 0, 0, 1, S_DECODE, NO, 6);
    cyc(OP_J, 0, 0, 1, S_JUMP,   PC, 6); sel(0, 0, 0, 0, 2'b00, 2'b10, 3'b000);

    // sw with one wait in MEMWR: single Memwrite pulse
    cyc(OP_SW, 0, 0, 1, S_FETCH,  FE, 7);
    cyc(OP_SW, 0, 0, 1, S_DECODE, NO, 7);
    cyc(OP_SW, 0, 0, 1, S_MEMADR, NO, 7);
    cyc(OP_SW, 0, 0, 0, S_MEMWR,  NO, 7); sel(0, 0, 1, 0, 2'b00, 2'b00, 3'b000);
    cyc(OP_SW, 0, 0, 1, S_MEMWR,  MW, 7);

    // addi
    cyc(OP_ADDI, 0, 0, 1, S_FETCH,  FE, 8);
    cyc(OP_ADDI, 0, 0, 1, S_DECODE, NO, 8);
    cyc(OP_ADDI, 0, 0, 1, S_ADDIEX, NO, 8); sel(0, 0, 0, 1, 2'b10, 2'b00, ALU_ADD);
    cyc(OP_ADDI, 0, 0, 1, S_ADDIWB, RW, 8); sel(0, 0, 0, 0, 2'b00, 2'b00, 3'b000);

    // illegal opcode traps and sticks
    cyc(BAD,  0, 0, 1, S_FETCH,  FE, 9);
    cyc(BAD,  0, 0, 1, S_DECODE, NO, 9);
    cyc(BAD,  0, 0, 1, S_TRAP,   NO, 9, 1'b1);
    cyc(BAD,  0, 1, 1, S_TRAP,   NO, 9, 1'b1);
    cyc(OP_J, 0, 0, 1, S_TRAP,   NO, 9, 1'b1);
    rst_v = 1'b0;
    cyc(OP_J, 0, 0, 1, S_FETCH, NO, 0);
    rst_v = 1'b1;
    cyc(OP_J, 0, 0, 0, S_FETCH, NO, 0);

    // illegal funct traps from EXEC
    cyc(OP_RTYPE, BAD, 0, 1, S_FETCH,  FE, 0);
    cyc(OP_RTYPE, BAD, 0, 1, S_DECODE, NO, 0);
    cyc(OP_RTYPE, BAD, 0, 1, S_EXEC,   NO, 0);
    cyc(OP_RTYPE, BAD, 0, 1, S_TRAP,   NO, 0, 1'b1);
    cyc(OP_RTYPE, BAD, 0, 1, S_TRAP,   NO, 0, 1'b1);

    // no-trap, no-handshake, 4-bit counter variant: illegals retire as NOPs
    // and mem_ready held low must not stall.
    rst_v = 1'b0;
    cyc(BAD, 0, 0, 0, S_FETCH, NO, 0, 1'b0, 1);
    rst_v = 1'b1;
    for (int k = 0; k < 15; k++) begin
      cyc(BAD, 0, 0, 0, S_FETCH,  FE, k, 1'b0, 1);
      cyc(BAD, 0, 0, 0, S_DECODE, NO, k, 1'b0, 1);
    end
    cyc(OP_RTYPE, BAD, 0, 0, S_FETCH,  FE, 15, 1'b0, 1);
    cyc(OP_RTYPE, BAD, 0, 0, S_DECODE, NO, 15, 1'b0, 1);
    cyc(OP_RTYPE, BAD, 0, 0, S_EXEC,   NO, 15, 1'b0, 1);
    cyc(BAD,      0,   0, 0, S_FETCH,  FE, 0,  1'b0, 1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    n_assert++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
